gpio_led_ctrl: RTL and testbench

- Board-level GPIO controller beside rtl_top on the ZCU106 top.
- Synchronises and debounces the five push-buttons and eight switches.
- Owns the 8-bit LED bank and shares it between four status requesters from the design (e.g. PCIe link/LTSSM, NVMe state, DMA activity, firmware). Ownership is decided by round-robin or by manual selection, with a heartbeat shown when no requester is active.

---
 rtl/gpio_led_ctrl_if.sv | 10 +
 rtl/gpio_led_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_gpio_led_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_led_ctrl_if.sv
// Requester-facing bus of the LED controller: status requests/patterns in, current owner out.
interface gpio_led_ctrl_if;
  logic [3:0]  src_req;
  logic [31:0] src_data;
  logic [1:0]  owner;
  logic        owner_valid;

  modport master (output src_req, output src_data, input owner, input owner_valid);
  modport slave  (input src_req, input src_data, output owner, output owner_valid);
endinterface

// File: rtl/gpio_led_ctrl.sv
// Board GPIO controller: button/switch sync + debounce, LED bank arbitration between
// four status requesters (AUTO round-robin / MANUAL select) with an idle heartbeat.
//
// state | meaning
// IDLE  | no owner in AUTO (heartbeat shown); also the parked state in MANUAL
// SHOW  | AUTO owner displayed, dwell counter running
module gpio_led_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int DWELL_CYCLES     = 50000000,
  parameter int HEARTBEAT_CYCLES = 25000000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       btn,
  input  logic [7:0]       sw,
  gpio_led_ctrl_if.slave   req_bus,
  output logic [7:0]       led,
  output logic [4:0]       btn_pulse,
  output logic [7:0]       sw_db,
  output logic             mode_manual
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int DWW = $clog2(DWELL_CYCLES);
  localparam int HBW = $clog2(HEARTBEAT_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DWW-1:0] DW_LAST = DWW'(DWELL_CYCLES - 1);
  localparam logic [HBW-1:0] HB_LAST = HBW'(HEARTBEAT_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  logic [1:0]     rst_sync;
  logic           rst_int_n;
  logic [12:0]    raw, meta, sync, db;
  logic [DBW-1:0] db_cnt [13];
  logic [4:0]     btn_db_q;
  logic [HBW-1:0] hb_cnt;
  logic           hb;
  state_t         state;
  logic [DWW-1:0] dwell;
  logic [1:0]     last_grant;
  logic [1:0]     owner_q;
  logic           owner_valid_q;
  logic           freeze;
  logic           mode_nx;
  logic [2:0]     pick;

  // Circular search starting one past 'last'; bit 2 flags that a requester was found.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      idx = last + 2'd1 + 2'(k);
      if (req[idx] && !r[2]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync <= '0;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign raw = {sw, btn};

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      db <= '0;
      for (int i = 0; i < 13; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 13; i++) begin
        if (sync[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      btn_db_q  <= '0;
      btn_pulse <= '0;
    end else begin
      btn_db_q  <= db[4:0];
      btn_pulse <= db[4:0] & ~btn_db_q;
    end
  end
  assign sw_db = db[12:5];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + HBW'(1);
    end
  end

  // The mode toggle takes effect before btnl/btnr are interpreted.
  assign mode_nx = mode_manual ^ btn_pulse[4];
  assign pick    = rr_pick(req_bus.src_req, last_grant);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state         <= IDLE;
      dwell         <= '0;
      last_grant    <= 2'd3;
      owner_q       <= 2'd0;
      owner_valid_q <= 1'b0;
      mode_manual   <= 1'b0;
      freeze        <= 1'b0;
    end else begin
      mode_manual <= mode_nx;
      if (btn_pulse[2])      freeze <= 1'b0;
      else if (btn_pulse[0]) freeze <= 1'b1;

      if (mode_nx) begin
        state         <= IDLE;
        dwell         <= '0;
        owner_valid_q <= 1'b1;
        if (btn_pulse[3] && !btn_pulse[1])      owner_q <= owner_q + 2'd1;
        else if (btn_pulse[1] && !btn_pulse[3]) owner_q <= owner_q - 2'd1;
      end else if (mode_manual) begin
        state         <= IDLE;
        dwell         <= '0;
        owner_valid_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pick[2]) begin
              owner_q       <= pick[1:0];
              last_grant    <= pick[1:0];
              owner_valid_q <= 1'b1;
              dwell         <= '0;
              state         <= SHOW;
            end else begin
              owner_valid_q <= 1'b0;
            end
          end
          SHOW: begin
            if (!req_bus.src_req[owner_q] || dwell == DW_LAST) begin
              if (pick[2]) begin
                owner_q    <= pick[1:0];
                last_grant <= pick[1:0];
                dwell      <= '0;
              end else begin
                owner_valid_q <= 1'b0;
                dwell         <= '0;
                state         <= IDLE;
              end
            end else begin
              dwell <= dwell + DWW'(1);
            end
          end
        endcase
      end
    end
  end

  assign req_bus.owner       = owner_q;
  assign req_bus.owner_valid = owner_valid_q;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)         led <= '0;
    else if (sw_db[7])      led <= '0;
    else if (freeze)        led <= led;
    else if (owner_valid_q) led <= req_bus.src_data[{owner_q, 3'b000} +: 8];
    else                    led <= {7'b0, hb};
  end

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Scoreboard bench for gpio_led_ctrl with short debounce/dwell/heartbeat parameters.
module tb_gpio_led_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [4:0] btn = '0;
  logic [7:0] sw = '0;
  logic [7:0] led;
  logic [4:0] btn_pulse;
  logic [7:0] sw_db;
  logic       mode_manual;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] owner;
    logic [7:0] led;
    bit         led_chk;
  } exp_t;
  exp_t sb[$];

  gpio_led_ctrl_if bus();

  gpio_led_ctrl #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(8), .HEARTBEAT_CYCLES(5)) dut (
    .clk(clk), .rstn(rstn), .btn(btn), .sw(sw), .req_bus(bus),
    .led(led), .btn_pulse(btn_pulse), .sw_db(sw_db), .mode_manual(mode_manual)
  );

  always #5 clk = ~clk;

  task automatic press(input int i);
    btn[i] = 1'b1;
    repeat (10) @(negedge clk);
    btn[i] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.src_req = '0;
    bus.src_data = 32'h44332211;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (led !== 8'h00) begin failures++; $display("FAIL rst_led got %h exp 00", led); end
    checks++; if (btn_pulse !== 5'h00) begin failures++; $display("FAIL rst_pulse got %h exp 00", btn_pulse); end
    checks++; if (sw_db !== 8'h00) begin failures++; $display("FAIL rst_sw_db got %h exp 00", sw_db); end
    checks++; if (mode_manual !== 1'b0) begin failures++; $display("FAIL rst_mode got %b exp 0", mode_manual); end
    checks++; if (bus.owner !== 2'd0) begin failures++; $display("FAIL rst_owner got %0d exp 0", bus.owner); end
    checks++; if (bus.owner_valid !== 1'b0) begin failures++; $display("FAIL rst_owner_valid got %b exp 0", bus.owner_valid); end
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_heartbeat();
    logic [7:0] prev, v;
    bit found;
    exp_t e;
    found = 1'b0;
    @(negedge clk);
    prev = led;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (led !== prev) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL hb_toggle_seen got 0 exp 1"); end
    v = led;
    checks++; if (v[7:1] !== 7'd0) begin failures++; $display("FAIL hb_upper_bits got %h exp 0x", v); end
    for (int k = 0; k < 14; k++) begin
      e.owner = 2'd0; e.led_chk = 1'b1;
      e.led = (k < 4) ? v : (k < 9) ? (v ^ 8'd1) : v;
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (led !== e.led) begin failures++; $display("FAIL hb_led got %h exp %h", led, e.led); end
      checks++; if (bus.owner_valid !== 1'b0) begin failures++; $display("FAIL hb_owner_valid got %b exp 0", bus.owner_valid); end
    end
  endtask

  task automatic test_auto_rr();
    exp_t e;
    @(negedge clk);
    bus.src_data = 32'h44332211;
    bus.src_req = 4'b0101;
    for (int k = 1; k <= 24; k++) begin
      e.owner = (k <= 8) ? 2'd0 : (k <= 16) ? 2'd2 : 2'd0;
      e.led_chk = (k >= 2);
      e.led = (k <= 9) ? 8'h11 : (k <= 17) ? 8'h33 : 8'h11;
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (bus.owner !== e.owner) begin failures++; $display("FAIL rr_owner got %0d exp %0d", bus.owner, e.owner); end
      checks++; if (bus.owner_valid !== 1'b1) begin failures++; $display("FAIL rr_owner_valid got %b exp 1", bus.owner_valid); end
      if (e.led_chk) begin
        checks++; if (led !== e.led) begin failures++; $display("FAIL rr_led got %h exp %h", led, e.led); end
      end
    end
  endtask

  task automatic test_drop();
    exp_t e;
    bus.src_req = 4'b1100;
    e.owner = 2'd2; e.led = 8'h11; e.led_chk = 1'b1; sb.push_back(e);
    e.owner = 2'd2; e.led = 8'h33; sb.push_back(e);
    e.owner = 2'd2; e.led = 8'h33; sb.push_back(e);
    e.owner = 2'd3; e.led = 8'h33; sb.push_back(e);
    e.owner = 2'd3; e.led = 8'h44; sb.push_back(e);
    e.owner = 2'd3; e.led = 8'h44; sb.push_back(e);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (bus.owner !== e.owner) begin failures++; $display("FAIL drop_owner got %0d exp %0d", bus.owner, e.owner); end
      checks++; if (led !== e.led) begin failures++; $display("FAIL drop_led got %h exp %h", led, e.led); end
      if (k == 2) bus.src_req = 4'b1000;
    end
    bus.src_req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_debounce();
    int pulses, other;
    pulses = 0; other = 0;
    btn[4] = 1'b1;
    repeat (3) @(negedge clk);
    btn[4] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (btn_pulse[4]) pulses++;
      if (btn_pulse[3:0] != 4'd0) other++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL glitch_pulses got %0d exp 0", pulses); end
    checks++; if (mode_manual !== 1'b0) begin failures++; $display("FAIL glitch_mode got %b exp 0", mode_manual); end
    btn[4] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 10) btn[4] = 1'b0;
      if (btn_pulse[4]) pulses++;
      if (btn_pulse[3:0] != 4'd0) other++;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
    checks++; if (other != 0) begin failures++; $display("FAIL stray_pulses got %0d exp 0", other); end
    checks++; if (mode_manual !== 1'b1) begin failures++; $display("FAIL hold_mode got %b exp 1", mode_manual); end
  endtask

  task automatic test_manual();
    exp_t e;
    bus.src_req = 4'b0000;
    e.owner = 2'd0; e.led = 8'h11; e.led_chk = 1'b1; sb.push_back(e);
    press(3);
    e = sb.pop_front();
    checks++; if (bus.owner !== e.owner) begin failures++; $display("FAIL man_btnr_owner got %0d exp %0d", bus.owner, e.owner); end
    checks++; if (led !== e.led) begin failures++; $display("FAIL man_btnr_led got %h exp %h", led, e.led); end
    e.owner = 2'd3; e.led = 8'h44; sb.push_back(e);
    press(1);
    e = sb.pop_front();
    checks++; if (bus.owner !== e.owner) begin failures++; $display("FAIL man_btnl_owner got %0d exp %0d", bus.owner, e.owner); end
    checks++; if (bus.owner_valid !== 1'b1) begin failures++; $display("FAIL man_owner_valid got %b exp 1", bus.owner_valid); end
    checks++; if (led !== e.led) begin failures++; $display("FAIL man_btnl_led got %h exp %h", led, e.led); end
    press(0);
    bus.src_data = 32'hDDCCBBAA;
    e.led = 8'h44; sb.push_back(e);
    repeat (4) @(negedge clk);
    e = sb.pop_front();
    checks++; if (led !== e.led) begin failures++; $display("FAIL freeze_led got %h exp %h", led, e.led); end
    e.led = 8'hDD; sb.push_back(e);
    press(2);
    e = sb.pop_front();
    checks++; if (led !== e.led) begin failures++; $display("FAIL unfreeze_led got %h exp %h", led, e.led); end
  endtask

  task automatic test_blank();
    sw = 8'h80;
    repeat (12) @(negedge clk);
    checks++; if (sw_db !== 8'h80) begin failures++; $display("FAIL blank_sw_db got %h exp 80", sw_db); end
    checks++; if (led !== 8'h00) begin failures++; $display("FAIL blank_led_manual got %h exp 00", led); end
    press(4);
    bus.src_req = 4'b0001;
    repeat (5) @(negedge clk);
    checks++; if (mode_manual !== 1'b0) begin failures++; $display("FAIL blank_mode got %b exp 0", mode_manual); end
    checks++; if (bus.owner_valid !== 1'b1) begin failures++; $display("FAIL blank_owner_valid got %b exp 1", bus.owner_valid); end
    checks++; if (led !== 8'h00) begin failures++; $display("FAIL blank_led_auto got %h exp 00", led); end
    sw = 8'h00;
    repeat (12) @(negedge clk);
    checks++; if (sw_db !== 8'h00) begin failures++; $display("FAIL unblank_sw_db got %h exp 00", sw_db); end
    checks++; if (led !== 8'hAA) begin failures++; $display("FAIL unblank_led got %h exp aa", led); end
  endtask

  task automatic test_reset_mid();
    bit found;
    bus.src_req = 4'b0010;
    repeat (3) @(negedge clk);
    checks++; if (bus.owner !== 2'd1) begin failures++; $display("FAIL pre_rst_owner got %0d exp 1", bus.owner); end
    rstn = 1'b0;
    bus.src_req = 4'b1001;
    #1;
    checks++; if (led !== 8'h00) begin failures++; $display("FAIL mid_rst_led got %h exp 00", led); end
    checks++; if (bus.owner !== 2'd0) begin failures++; $display("FAIL mid_rst_owner got %0d exp 0", bus.owner); end
    checks++; if (bus.owner_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_owner_valid got %b exp 0", bus.owner_valid); end
    checks++; if (mode_manual !== 1'b0) begin failures++; $display("FAIL mid_rst_mode got %b exp 0", mode_manual); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.owner_valid === 1'b1) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL post_rst_grant got 0 exp 1"); end
    checks++; if (bus.owner !== 2'd0) begin failures++; $display("FAIL post_rst_owner got %0d exp 0", bus.owner); end
    @(negedge clk);
    checks++; if (led !== 8'hAA) begin failures++; $display("FAIL post_rst_led got %h exp aa", led); end
  endtask

  initial begin
    test_reset();
    test_heartbeat();
    test_auto_rr();
    test_drop();
    test_debounce();
    test_manual();
    test_blank();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
